// File: rtl/instr_compressor.sv
// RV32I -> RV32C packer: compresses eligible instructions and packs halfwords into 32-bit memory words.
// Optional build macro COMPRESSOR_STATS_EN adds accepted/compressed instruction counters.
`timescale 1ns/1ps

module instr_compressor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_word_o,
    output logic        flush_done_o
`ifdef COMPRESSOR_STATS_EN
    ,
    output logic [15:0] stat_total_o,
    output logic [15:0] stat_comp_o
`endif
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm_i, imm_s;
    logic [12:1] off_b;
    logic [20:1] off_j;
    logic        rd_p, rs1_p, rs2_p;
    logic        imm_i_small, lw_ok, sw_ok, off_b_ok, off_j_ok;
    logic        is_comp;
    logic [15:0] c16;

    assign opcode = in_instr_i[6:0];
    assign funct3 = in_instr_i[14:12];
    assign funct7 = in_instr_i[31:25];
    assign rd     = in_instr_i[11:7];
    assign rs1    = in_instr_i[19:15];
    assign rs2    = in_instr_i[24:20];
    assign imm_i  = in_instr_i[31:20];
    assign imm_s  = {in_instr_i[31:25], in_instr_i[11:7]};
    assign off_b  = {in_instr_i[31], in_instr_i[7], in_instr_i[30:25], in_instr_i[11:8]};
    assign off_j  = {in_instr_i[31], in_instr_i[19:12], in_instr_i[20], in_instr_i[30:21]};

    // Range checks: the dropped upper immediate bits must be pure sign extension
    assign rd_p        = (rd[4:3]  == 2'b01);
    assign rs1_p       = (rs1[4:3] == 2'b01);
    assign rs2_p       = (rs2[4:3] == 2'b01);
    assign imm_i_small = (&imm_i[11:5]) | ~(|imm_i[11:5]);
    assign lw_ok       = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
    assign sw_ok       = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);
    assign off_b_ok    = (&off_b[12:8]) | ~(|off_b[12:8]);
    assign off_j_ok    = (&off_j[20:11]) | ~(|off_j[20:11]);

    always_comb begin
        is_comp = 1'b0;
        c16     = 16'h0000;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0) begin
                    if (rs1 == rd) begin
                        is_comp = 1'b1;
                        c16     = {4'b1001, rd, rs2, 2'b10};
                    end else if (rs1 == 5'd0) begin
                        is_comp = 1'b1;
                        c16     = {4'b1000, rd, rs2, 2'b10};
                    end
                end
            end
            7'b1100111: begin
                if (funct3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 && (rd == 5'd0 || rd == 5'd1)) begin
                    is_comp = 1'b1;
                    c16     = {3'b100, rd[0], rs1, 5'd0, 2'b10};
                end
            end
            7'b0010011: begin
                case (funct3)
                    3'b000: if (rd != 5'd0 && rd == rs1 && imm_i_small) begin
                        is_comp = 1'b1;
                        c16     = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                    end
                    3'b001: if (funct7 == 7'd0 && rd != 5'd0 && rd == rs1 && rs2 != 5'd0) begin
                        is_comp = 1'b1;
                        c16     = {4'b0000, rd, rs2, 2'b10};
                    end
                    3'b101: if ((funct7 == 7'd0 || funct7 == 7'b0100000) && rd == rs1 && rd_p && rs2 != 5'd0) begin
                        is_comp = 1'b1;
                        c16     = {5'b10000, funct7[5], rd[2:0], rs2, 2'b01};
                    end
                    3'b111: if (rd == rs1 && rd_p && imm_i_small) begin
                        is_comp = 1'b1;
                        c16     = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
                    end
                    default: ;
                endcase
            end
            7'b0000011: begin
                if (funct3 == 3'b010 && rd_p && rs1_p && lw_ok) begin
                    is_comp = 1'b1;
                    c16     = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b010 && rs1_p && rs2_p && sw_ok) begin
                    is_comp = 1'b1;
                    c16     = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                end
            end
            7'b1100011: begin
                if (funct3[2:1] == 2'b00 && rs2 == 5'd0 && rs1_p && off_b_ok) begin
                    is_comp = 1'b1;
                    c16     = {2'b11, funct3[0], off_b[8], off_b[4:3], rs1[2:0],
                               off_b[7:6], off_b[2:1], off_b[5], 2'b01};
                end
            end
            7'b1101111: begin
                if (off_j_ok && (rd == 5'd0 || rd == 5'd1)) begin
                    is_comp = 1'b1;
                    c16     = {~rd[0], 2'b01, off_j[11], off_j[4], off_j[9:8], off_j[10],
                               off_j[6], off_j[7], off_j[3:1], off_j[5], 2'b01};
                end
            end
            default: ;
        endcase
    end

    logic        pend_valid;
    logic [15:0] pend_half;
    logic        flush_pend;
    logic        accept, slot_free, flush_exec;
    logic        emit;
    logic [31:0] emit_word;
    logic        p_next;
    logic [15:0] h_next;

    assign slot_free  = !out_valid_o | out_ready_i;
    assign in_ready_o = slot_free & !flush_pend;
    assign accept     = in_valid_i & in_ready_o;
    assign flush_exec = flush_pend & slot_free;

    always_comb begin
        emit      = 1'b0;
        emit_word = in_instr_i;
        p_next    = pend_valid;
        h_next    = pend_half;
        if (accept) begin
            if (!pend_valid) begin
                if (is_comp) begin
                    h_next = c16;
                    p_next = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end else if (is_comp) begin
                emit      = 1'b1;
                emit_word = {c16, pend_half};
                p_next    = 1'b0;
            end else begin
                // A 32-bit instruction straddles the word boundary; its upper half stays pending
                emit      = 1'b1;
                emit_word = {in_instr_i[15:0], pend_half};
                h_next    = in_instr_i[31:16];
            end
        end else if (flush_exec && pend_valid) begin
            emit      = 1'b1;
            emit_word = {16'h0001, pend_half};
            p_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid   <= 1'b0;
            pend_half    <= 16'h0000;
            flush_pend   <= 1'b0;
            flush_done_o <= 1'b0;
            out_valid_o  <= 1'b0;
            out_word_o   <= 32'h0000_0000;
        end else begin
            pend_valid   <= p_next;
            pend_half    <= h_next;
            flush_pend   <= flush_exec ? 1'b0 : (flush_pend | flush_i);
            flush_done_o <= flush_exec;
            if (emit) begin
                out_valid_o <= 1'b1;
                out_word_o  <= emit_word;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

`ifdef COMPRESSOR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total_o <= 16'h0000;
            stat_comp_o  <= 16'h0000;
        end else if (accept) begin
            stat_total_o <= stat_total_o + 16'd1;
            if (is_comp) stat_comp_o <= stat_comp_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_compressor.sv
// Directed, table-driven bench for instr_compressor; the stats check runs only with COMPRESSOR_STATS_EN.
`timescale 1ns/1ps

module tb_instr_compressor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_instr_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_word_o;
    logic        flush_done_o;
`ifdef COMPRESSOR_STATS_EN
    logic [15:0] stat_total_o;
    logic [15:0] stat_comp_o;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [31:0] ADD_X10 = 32'h00B50533;
    localparam logic [31:0] LUI_RAW = 32'h123452B7;

    typedef struct packed {
        logic [31:0] instr;
        logic        comp;
        logic [15:0] c16;
    } vec_t;

    vec_t vecs[$];

    instr_compressor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_instr_i   (in_instr_i),
        .flush_i      (flush_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_word_o   (out_word_o),
        .flush_done_o (flush_done_o)
`ifdef COMPRESSOR_STATS_EN
        ,
        .stat_total_o (stat_total_o),
        .stat_comp_o  (stat_comp_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offers one instruction and returns on the negedge after it was accepted
    task automatic applyStimulus(input logic [31:0] instr);
        int waited = 0;
        @(negedge clk);
        in_valid_i = 1'b1;
        in_instr_i = instr;
        while (!in_ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready_o) begin
            checkOutput("accept_timeout", {31'd0, in_ready_o}, 32'd1);
            in_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid_i = 1'b0;
        end
    endtask

    task automatic pulseFlush();
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        in_instr_i  = 32'h0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;

        vecs.push_back('{ADD_X10,      1'b1, 16'h952E});
        vecs.push_back('{32'hFFF40413, 1'b1, 16'h147D});
        vecs.push_back('{32'h01F40413, 1'b1, 16'h047D});
        vecs.push_back('{32'h02040413, 1'b0, 16'h0000});
        vecs.push_back('{32'h006002B3, 1'b1, 16'h829A});
        vecs.push_back('{32'h007302B3, 1'b0, 16'h0000});
        vecs.push_back('{32'h00008067, 1'b1, 16'h8082});
        vecs.push_back('{32'h000280E7, 1'b1, 16'h9282});
        vecs.push_back('{32'h004280E7, 1'b0, 16'h0000});
        vecs.push_back('{32'h00349493, 1'b1, 16'h048E});
        vecs.push_back('{32'h00049493, 1'b0, 16'h0000});
        vecs.push_back('{32'h40455513, 1'b1, 16'h8511});
        vecs.push_back('{32'h00455513, 1'b1, 16'h8111});
        vecs.push_back('{32'h00485813, 1'b0, 16'h0000});
        vecs.push_back('{32'hFFC5F593, 1'b1, 16'h99F1});
        vecs.push_back('{32'h07C42483, 1'b1, 16'h5C64});
        vecs.push_back('{32'h08042483, 1'b0, 16'h0000});
        vecs.push_back('{32'h00242483, 1'b0, 16'h0000});
        vecs.push_back('{32'h00A5A423, 1'b1, 16'hC588});
        vecs.push_back('{32'hF00400E3, 1'b1, 16'hD001});
        vecs.push_back('{32'h0E049F63, 1'b1, 16'hECFD});
        vecs.push_back('{32'h10040063, 1'b0, 16'h0000});
        vecs.push_back('{32'h801FF0EF, 1'b1, 16'h3001});
        vecs.push_back('{32'h7FE0006F, 1'b1, 16'hAFFD});
        vecs.push_back('{32'h001000EF, 1'b0, 16'h0000});
        vecs.push_back('{32'h008002EF, 1'b0, 16'h0000});
        vecs.push_back('{LUI_RAW,      1'b0, 16'h0000});
        vecs.push_back('{32'h00000013, 1'b0, 16'h0000});

        #12;
        checkOutput("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("reset_out_word", out_word_o, 32'h0);
        checkOutput("reset_flush_done", {31'd0, flush_done_o}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Two compressed instructions pack into one word
        applyStimulus(ADD_X10);
        checkOutput("pack_first_no_out", {31'd0, out_valid_o}, 32'd0);
        applyStimulus(32'hFFF40413);
        checkOutput("pack_pair_valid", {31'd0, out_valid_o}, 32'd1);
        checkOutput("pack_pair_word", out_word_o, 32'h147D952E);

        applyStimulus(ADD_X10);
        applyStimulus(LUI_RAW);
        checkOutput("straddle_word", out_word_o, 32'h52B7952E);
        pulseFlush();
        checkOutput("flush_word", out_word_o, 32'h00011234);
        checkOutput("flush_valid", {31'd0, out_valid_o}, 32'd1);
        checkOutput("flush_done", {31'd0, flush_done_o}, 32'd1);

        pulseFlush();
        checkOutput("empty_flush_done", {31'd0, flush_done_o}, 32'd1);
        checkOutput("empty_flush_no_out", {31'd0, out_valid_o}, 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].instr);
            if (vecs[i].comp) begin
                checkOutput($sformatf("vec%0d_held", i), {31'd0, out_valid_o}, 32'd0);
                applyStimulus(LUI_RAW);
                checkOutput($sformatf("vec%0d_word", i), out_word_o, {16'h52B7, vecs[i].c16});
                pulseFlush();
                checkOutput($sformatf("vec%0d_flush", i), out_word_o, 32'h00011234);
            end else begin
                checkOutput($sformatf("vec%0d_valid", i), {31'd0, out_valid_o}, 32'd1);
                checkOutput($sformatf("vec%0d_raw", i), out_word_o, vecs[i].instr);
            end
        end

        // Flush on the same edge as an accepted instruction: instruction goes first
        @(negedge clk);
        in_valid_i = 1'b1;
        in_instr_i = ADD_X10;
        flush_i    = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
        checkOutput("coflush_no_out", {31'd0, out_valid_o}, 32'd0);
        checkOutput("coflush_blocked", {31'd0, in_ready_o}, 32'd0);
        @(negedge clk);
        checkOutput("coflush_word", out_word_o, 32'h0001952E);
        checkOutput("coflush_done", {31'd0, flush_done_o}, 32'd1);
        @(negedge clk);
        checkOutput("coflush_done_drop", {31'd0, flush_done_o}, 32'd0);

        // A second flush request while one is pending is absorbed
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        checkOutput("absorb_done", {31'd0, flush_done_o}, 32'd1);
        @(negedge clk);
        checkOutput("absorb_single_pulse", {31'd0, flush_done_o}, 32'd0);

        // Backpressure: word held for 5 cycles, then transfer completes
        out_ready_i = 1'b0;
        applyStimulus(LUI_RAW);
        in_valid_i = 1'b1;
        in_instr_i = 32'h02040413;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_word%0d", k), out_word_o, LUI_RAW);
            checkOutput($sformatf("bp_valid%0d", k), {31'd0, out_valid_o}, 32'd1);
            checkOutput($sformatf("bp_ready%0d", k), {31'd0, in_ready_o}, 32'd0);
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        #1;
        checkOutput("bp_release_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk);
        in_valid_i = 1'b0;
        checkOutput("bp_next_word", out_word_o, 32'h02040413);
        @(negedge clk);
        checkOutput("bp_drained", {31'd0, out_valid_o}, 32'd0);

        // Asynchronous reset drops an undelivered word immediately
        out_ready_i = 1'b0;
        applyStimulus(LUI_RAW);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_drop_valid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("rst_drop_word", out_word_o, 32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        out_ready_i = 1'b1;

        // Asynchronous reset discards a pending halfword
        applyStimulus(ADD_X10);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("rst_mid_done", {31'd0, flush_done_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(LUI_RAW);
        checkOutput("rst_mid_after", out_word_o, LUI_RAW);

`ifdef COMPRESSOR_STATS_EN
        resetDut();
        @(negedge clk);
        in_valid_i = 1'b1;
        in_instr_i = ADD_X10;
        repeat (65537) @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        checkOutput("stat_comp_wrap", {16'd0, stat_comp_o}, 32'd1);
        checkOutput("stat_total_wrap", {16'd0, stat_total_o}, 32'd1);
        applyStimulus(LUI_RAW);
        checkOutput("stat_total_raw", {16'd0, stat_total_o}, 32'd2);
        checkOutput("stat_comp_raw", {16'd0, stat_comp_o}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_compressor.md
INSTR_COMPRESSOR -- requirements
Module: instr_compressor

Interface
REQ-001 SHALL have clk, input, 1, single clock; all flops rise-edge triggered.
REQ-002 SHALL have rst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have in_valid_i, input, 1, a 32-bit RV32I instruction is offered.
REQ-004 SHALL have in_ready_o, output, 1, the block accepts the offered instruction this cycle.
REQ-005 SHALL have in_instr_i, input, 32, uncompressed instruction.
REQ-006 SHALL have flush_i, input, 1, single-cycle request to emit any pending halfword.
REQ-007 SHALL have out_valid_o, output, 1, out_word_o holds a packed word.
REQ-008 SHALL have out_ready_i, input, 1, the consumer takes out_word_o.
REQ-009 SHALL have out_word_o, output, 32, packed instruction memory word; bits [15:0] hold the lower address.
REQ-010 SHALL have flush_done_o, output, 1, one-cycle pulse when a flush completes.

Function
REQ-011 SHALL compress, with rd/rs1/rs2 the 32-bit fields: ADD with rd=rs1!=0 and rs2!=0 -> C.ADD; ADD with rs1=0, rd!=0, rs2!=0 -> C.MV; JALR with imm=0, rs1!=0, rd=0 -> C.JR; the same with rd=1 -> C.JALR.
REQ-012 SHALL compress ADDI with rd=rs1!=0 and imm in [-32,31] -> C.ADDI; SLLI with rd=rs1!=0 and shamt in 1..31 -> C.SLLI.
REQ-013 SHALL compress SRLI/SRAI with rd=rs1 in x8..x15 and shamt 1..31, and ANDI with rd=rs1 in x8..x15 and imm in [-32,31], -> C.SRLI/C.SRAI/C.ANDI.
REQ-014 SHALL compress LW/SW with registers in x8..x15 and offset a multiple of 4 in [0,124] -> C.LW/C.SW.
REQ-015 SHALL compress BEQ/BNE with rs2=0, rs1 in x8..x15 and even offset in [-256,254] -> C.BEQZ/C.BNEZ; JAL with even offset in [-2048,2046] and rd=1 -> C.JAL, rd=0 -> C.J.
REQ-016 SHALL pass every other instruction, including out-of-range or boundary-violating forms of the above, unchanged as 32 bits.
REQ-017 SHALL keep state P (pending valid) plus a 16-bit pending halfword H.
REQ-018 SHALL pack as follows on accept:
- P=0, compressed: H<=c16, P<=1, no word emitted.
- P=0, 32-bit: emit instr.
- P=1, compressed: emit {c16,H}, P<=0.
- P=1, 32-bit: emit {instr[15:0],H}, H<=instr[31:16], P stays 1.
REQ-019 SHALL register the output: a word emitted on an accepting edge appears on out_word_o with out_valid_o=1 from that edge, a latency of one cycle.
REQ-020 SHALL hold out_word_o/out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-021 SHALL drive in_ready_o = (!out_valid_o | out_ready_i) & !flush_pend, combinationally.
REQ-022 SHALL handle flush_i as follows:
- Capture flush_i into flush_pend.
- flush_i coincident with an accepted instruction: the instruction is processed first.
- When flush_pend=1 and the output slot is free: if P=1, emit {16'h0001 (C.NOP),H} and set P<=0; pulse flush_done_o and clear flush_pend in the same cycle.
- A flush_i arriving while flush_pend=1 is absorbed.
REQ-023 SHALL never emit a word on flush when P=0; flush_done_o still pulses.

Reset
REQ-024 SHALL on rst_n=0 immediately clear P, H=0, flush_pend, out_valid_o=0, out_word_o=0 and flush_done_o=0; any pending halfword or undelivered word is discarded.
REQ-025 SHALL accept the first instruction on the first clock edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with COMPRESSOR_STATS_EN defined:
- Add outputs stat_total_o[15:0] (accepted instructions) and stat_comp_o[15:0] (compressed instructions).
- Both counters reset to 0, increment on accept and wrap from 0xFFFF to 0.
REQ-027 SHALL, without COMPRESSOR_STATS_EN, omit those ports and counters entirely.

Verification
REQ-028 SHALL verify from reset: in 0x00B50533 (ADD x10,x10,x11), then 0xFFF40413 (ADDI x8,x8,-1) -> a single out word 0x147D952E.
REQ-029 SHALL verify: in 0x00B50533, then 0x123452B7 (LUI) -> out 0x52B7952E; then flush_i -> out 0x00011234 and a flush_done_o pulse.
REQ-030 SHALL verify the ADDI range boundary: with P=0, in 0x02040413 (imm 32) -> raw out 0x02040413; in 0x01F40413 (imm 31) -> H=0x047D and no output.
REQ-031 SHALL verify backpressure: hold out_ready_i=0 with out_valid_o=1 for 5 cycles -> out_word_o unchanged, in_ready_o=0; the next out_ready_i=1 cycle completes the transfer.
REQ-032 SHALL verify reset mid-operation: P=1 with H=0x952E, assert rst_n=0 -> out_valid_o=0 and, after release, in 0x123452B7 -> out 0x123452B7.
REQ-033 SHALL verify with COMPRESSOR_STATS_EN: 65537 accepted compressible instructions -> stat_comp_o=1 and stat_total_o=1.
